// File: rtl/crc24_rx_check.sv
// Receive-side BLE CRC-24 checker: runs the LFSR over header+payload bits,
// then compares the trailing 24 received CRC bits against the remainder.
module crc24_rx_check #(
   parameter int CRC_STATE_BIT_WIDTH = 24,
   parameter int LEN_BIT_WIDTH       = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init_bit,
   input  logic                           start,
   input  logic [LEN_BIT_WIDTH-1:0]       pdu_len_byte,
   input  logic                           data_in,
   input  logic                           data_in_valid,
   output logic                           busy,
   output logic                           crc_done,
   output logic                           crc_ok,
   output logic [CRC_STATE_BIT_WIDTH-1:0] lfsr
);

   localparam int CNT_W = LEN_BIT_WIDTH + 4;
   // Feedback taps x^10+x^9+x^6+x^4+x^3+x+1; x^24 is the shifted-out MSB.
   localparam logic [CRC_STATE_BIT_WIDTH-1:0] CRC_POLY = CRC_STATE_BIT_WIDTH'(24'h00065B);

   typedef enum logic [1:0] {IDLE, INFO, CRC, DONE} state_t;

   state_t                           state;
   logic [CNT_W-1:0]                 info_cnt;
   logic [4:0]                       crc_cnt;
   logic                             err;
   logic                             nb;
   logic [CRC_STATE_BIT_WIDTH-1:0]   lfsr_nxt;
   logic [CRC_STATE_BIT_WIDTH-1:0]   lfsr_init;
   logic [CNT_W-1:0]                 info_bits;

   // nb doubles as the CRC-phase mismatch flag: received bit vs. lfsr MSB.
   always_comb begin
      nb        = lfsr[CRC_STATE_BIT_WIDTH-1] ^ data_in;
      lfsr_nxt  = {lfsr[CRC_STATE_BIT_WIDTH-2:0], 1'b0} ^ (nb ? CRC_POLY : '0);
      lfsr_init = {crc_state_init_bit[7:0], crc_state_init_bit[15:8], crc_state_init_bit[23:16]};
      info_bits = CNT_W'({pdu_len_byte, 3'b000}) + CNT_W'(16);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         crc_done <= 1'b0;
         crc_ok   <= 1'b0;
         lfsr     <= '0;
         info_cnt <= '0;
         crc_cnt  <= '0;
         err      <= 1'b0;
      end else begin
         crc_done <= 1'b0;
         if (start) begin
            state    <= INFO;
            busy     <= 1'b1;
            crc_ok   <= 1'b0;
            err      <= 1'b0;
            lfsr     <= lfsr_init;
            info_cnt <= info_bits;
            crc_cnt  <= '0;
         end else begin
            case (state)
               IDLE: ;
               INFO: begin
                  if (data_in_valid) begin
                     lfsr     <= lfsr_nxt;
                     info_cnt <= info_cnt - CNT_W'(1);
                     if (info_cnt == CNT_W'(1)) begin
                        state   <= CRC;
                        crc_cnt <= 5'd24;
                     end
                  end
               end
               CRC: begin
                  if (data_in_valid) begin
                     lfsr    <= lfsr_nxt;
                     err     <= err | nb;
                     crc_cnt <= crc_cnt - 5'd1;
                     if (crc_cnt == 5'd1) begin
                        state    <= DONE;
                        crc_done <= 1'b1;
                        crc_ok   <= ~(err | nb);
                        busy     <= 1'b0;
                     end
                  end
               end
               DONE: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/crc24_rx_check.md
Name: crc24_rx_check

Overview:
- Receive-side CRC-24 checker that sits directly after de-whitening in the BTLE receive chain.
- Takes the de-whitened PDU bit stream (16-bit LL header, then payload, then 24 CRC bits) and runs the BLE CRC-24 LFSR over the header and payload bits. It then checks the 24 received CRC bits against the LFSR remainder.
- Reports a one-cycle done pulse plus a held pass/fail flag to the packet/PDU layer.
- Contains its own LFSR with polynomial x^24+x^10+x^9+x^6+x^4+x^3+x+1 (taps 1,3,4,6,9,10).

Parameters:
CRC_STATE_BIT_WIDTH, 24, LFSR / CRC width (fixed at 24; other values unsupported)
LEN_BIT_WIDTH, 8, width of PDU payload length field in bytes

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
crc_state_init_bit  input  24  CRC init value, sampled on start (0x555555 for advertising)
start  input  1  one-cycle pulse: load init and length, begin new PDU
pdu_len_byte  input  LEN_BIT_WIDTH  payload length in bytes, sampled on start
data_in  input  1  de-whitened received bit, on-air order
data_in_valid  input  1  data_in qualifier; gaps allowed
busy  output  1  high from cycle after start until crc_done
crc_done  output  1  one-cycle pulse when 24th CRC bit has been checked
crc_ok  output  1  result; valid from crc_done, held until next start/reset
lfsr  output  24  current LFSR state (debug/observability)

Behaviour:
- Reset values: state=IDLE, busy=0, crc_done=0, crc_ok=0, lfsr=0, bit counter=0.
- On start, the LFSR is loaded with init byte-swapped:
  - lfsr[7:0]=init[23:16]
  - lfsr[15:8]=init[15:8]
  - lfsr[23:16]=init[7:0]
- Also on start: info_bits = (pdu_len_byte+2)*8 latched into a 12-bit down-counter; go to INFO.
- Update rule (every accepted bit), with nb = lfsr[23]^data_in:
  - lfsr[0]=nb
  - lfsr[1]=lfsr[0]^nb
  - lfsr[2]=lfsr[1]
  - lfsr[3]=lfsr[2]^nb
  - lfsr[4]=lfsr[3]^nb
  - lfsr[5]=lfsr[4]
  - lfsr[6]=lfsr[5]^nb
  - lfsr[8:7]=lfsr[7:6]
  - lfsr[9]=lfsr[8]^nb
  - lfsr[10]=lfsr[9]^nb
  - lfsr[23:11]=lfsr[22:10]
- States: IDLE, INFO, CRC, DONE.
  - IDLE: data_in_valid ignored; busy=0.
  - INFO: each valid bit updates the LFSR and decrements the counter. When the last info bit is accepted, go to CRC with a 5-bit counter of 24.
  - CRC: each valid bit is compared with the current lfsr[23].
    - Any mismatch sets a sticky err flag; the LFSR keeps updating with the normal rule (remainder drains to zero on a match).
    - After the 24th CRC bit, go to DONE.
  - DONE (one cycle): crc_done=1, crc_ok=~err, busy=0; next state IDLE.
  - Net timing: crc_done rises on the clock edge after the 24th CRC bit is accepted.
- Simultaneous / boundary events:
  - start always wins, in any state: reload and restart. A data_in_valid in the same cycle as start is dropped. crc_ok clears to 0 on start.
  - start coincident with DONE: crc_done still pulses for the old PDU and the new PDU begins.
  - pdu_len_byte=0 gives exactly 16 info bits.
  - pdu_len_byte=255 gives 2056 info bits (counter must not overflow).
  - valid gaps of any length in INFO/CRC stall the state and counters with no timeout.
  - rst mid-PDU returns to reset values immediately; crc_done is not pulsed.
- No pipelining: the LFSR update is registered, so the compare uses the pre-update lfsr[23] of the same cycle.

Test Plan:
- init=0x000000, len=0, 16 zero info bits, 24 zero CRC bits -> lfsr stays 0; crc_done one cycle after last bit; crc_ok=1.
- init=0x000001, len=0, 16 zero info bits -> lfsr=0x065B00 entering CRC. CRC bits MSB-first 0000_0110_0101_1011_0000_0000 -> crc_ok=1, lfsr=0 at done.
- Same as above with 6th CRC bit flipped -> crc_ok=0, crc_done still pulses after 24 CRC bits.
- init=0x555555, len=37, random payload with CRC from the C/Python model, data_in_valid 50% random gaps -> crc_ok=1; busy high throughout; done exactly once.
- start re-asserted mid-INFO after 100 bits, then a valid 16-bit PDU -> first PDU aborted with no crc_done; second gives crc_ok=1.
- rst pulsed mid-CRC phase -> busy=0, crc_ok=0, lfsr=0 immediately; no crc_done; a following PDU checks correctly.
